clock_display_driver: RTL and testbench
=======================================

CLOCK_DISPLAY_DRIVER -- requirements
Module: clock_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 4, meaning clk cycles per displayed digit (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sec  input  6  binary seconds from the time-keeping counter (legal range 0..59).
REQ-005 SHALL have port min  input  6  binary minutes (legal range 0..59).
REQ-006 SHALL have port hr  input  5  binary hours (legal range 0..23).
REQ-007 SHALL have port mode12  input  1  display format: 1 = 12-hour, 0 = 24-hour.
REQ-008 SHALL have port blank_en  input  1  1 = all digits dark.
REQ-009 SHALL have port an  output  6  one-hot digit enable, active-high; an[i] selects digit i.
REQ-010 SHALL have port seg  output  7  segments, active-high; seg[0]=a through seg[6]=g.
REQ-011 SHALL have port dp  output  1  decimal point of the selected digit, used as the colon.
REQ-012 SHALL have port pm  output  1  PM indicator.

Function
REQ-013 SHALL count div_cnt 0..SCAN_DIV-1 and wrap to 0; the edge on which div_cnt==SCAN_DIV-1 is an advance edge.
REQ-014 SHALL advance digit index 0..5 by 1 mod 6 on each advance edge.
REQ-015 SHALL sample {sec,min,hr,mode12} into a snapshot only on the advance edge where the index goes 5->0; input changes at any other time SHALL NOT change the current frame.
REQ-016 SHALL map digits as: 0 = hour tens (leftmost), 1 = hour units, 2 = minute tens, 3 = minute units, 4 = second tens, 5 = second units.
REQ-017 SHALL register an, seg, dp and pm on every edge from the digit index and snapshot held before that edge, giving 1-cycle latency.
REQ-018 SHALL, in 24-hour mode, display hr as two decimal digits with a leading zero (e.g. 7 -> "07").
REQ-019 SHALL, in 12-hour mode, display hr 0 as 12, hr 1..12 unchanged and hr 13..23 as hr-12; a hour-tens digit of 0 SHALL be blanked (an asserted, seg=0x00).
REQ-020 SHALL drive pm=1 when mode12=1 and snapshot hr>=12, else pm=0.
REQ-021 SHALL encode digits 0..9 as 0x3F,0x06,0x5B,0x4F,0x66,0x6D,0x7D,0x07,0x7F,0x6F.
REQ-022 SHALL drive dp=1 only while digit 1 or 3 is selected and snapshot sec is even, giving a colon that blinks at 0.5 Hz.
REQ-023 SHALL, when any snapshot field is out of range (sec>59, min>59 or hr>23), show every digit as 0x40 (dash), with dp=0 and pm=0, for that whole frame.
REQ-024 SHALL, when blank_en=1, drive an=0, seg=0 and dp=0 from the next edge while counters and snapshot keep running; pm SHALL be unaffected.
REQ-025 SHALL keep an exactly one-hot whenever blank_en=0 and rst=0.

Reset
REQ-026 SHALL, on rst=1, immediately clear div_cnt, snapshot, an, seg, dp and pm to 0 and set the digit index to 5, independent of clk.
REQ-027 SHALL start the first frame after reset release on the first advance edge, which captures a fresh snapshot.
REQ-028 SHALL show digit 5 of the all-zero snapshot (an=6'b100000, seg=0x3F) on the cycles between reset release and the first advance edge.
REQ-029 SHALL, when rst is asserted mid-frame, abandon the frame with no partial output held after rst deasserts.

Verification
REQ-030 SHALL cover: SCAN_DIV=4, mode12=0, hr=7 min=5 sec=42 held -> frame seg sequence 0x3F,0x07,0x3F,0x6D,0x66,0x5B with each an bit lasting 4 cycles; dp=1 on digits 1 and 3.
REQ-031 SHALL cover: mode12=1 with hr=0, 12, 13 and 23 -> displayed "12"(pm=0), "12"(pm=1), " 1"(pm=1), "11"(pm=1); the hour-tens digit is dark for " 1".
REQ-032 SHALL cover: sec changes 41->42 while digit 3 is selected -> the frame in progress still shows 41; the next frame shows 42 with dp=1.
REQ-033 SHALL cover: min=60 -> all six digits show 0x40 with dp=0; restoring min=59 -> correct display from the following frame.
REQ-034 SHALL cover: blank_en pulsed for 10 cycles -> an=0, seg=0 during the pulse; scanning resumes in phase afterwards (digit index has kept advancing).
REQ-035 SHALL cover: rst asserted asynchronously between clock edges mid-frame -> all outputs 0 immediately; after release an=6'b100000 until the first advance, then a fresh frame starts at digit 0.

Source files
------------

// File: rtl/clock_display_driver.sv
// Six-digit HH:MM:SS multiplexed 7-segment driver with per-frame snapshot.
// clk/rst (async, active-high); sec/min/hr/mode12 time in; blank_en dark;
// an one-hot digit, seg a..g, dp colon, pm indicator (all registered).
module clock_display_driver #(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hr,
  input  logic       mode12,
  input  logic       blank_en,
  output logic [5:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       pm
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  localparam logic [2:0] IDX_LAST = 3'd5;

  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF = 7'h00;

  typedef struct packed {
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hr;
    logic       mode12;
  } snap_t;

  logic [CW-1:0] div_cnt;
  logic [2:0]    idx;
  snap_t         snap;
  logic          adv;
  logic          wrap;

  logic [4:0] h12;
  logic [4:0] hsel;
  logic [7:0] hr_bcd;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       valid;
  logic       tens_dark;

  logic [3:0] digit;
  logic       dark;
  logic [5:0] an_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt;
  logic       pm_nxt;

  function automatic logic [6:0] enc7(
    input logic [3:0] d
  );
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Split 0..59 into {tens, units}.
  function automatic logic [7:0] to_bcd(
    input logic [5:0] v
  );
    logic [3:0] t;
    logic [3:0] u;
    if (v >= 6'd50) begin
      t = 4'd5;
      u = 4'(v - 6'd50);
    end else if (v >= 6'd40) begin
      t = 4'd4;
      u = 4'(v - 6'd40);
    end else if (v >= 6'd30) begin
      t = 4'd3;
      u = 4'(v - 6'd30);
    end else if (v >= 6'd20) begin
      t = 4'd2;
      u = 4'(v - 6'd20);
    end else if (v >= 6'd10) begin
      t = 4'd1;
      u = 4'(v - 6'd10);
    end else begin
      t = 4'd0;
      u = v[3:0];
    end
    return {t, u};
  endfunction

  assign adv  = (div_cnt == DIV_LAST);
  assign wrap = adv && (idx == IDX_LAST);

  // Index resets to the last digit so the first advance wraps to 0
  // and captures a fresh snapshot for the first real frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= IDX_LAST;
      snap    <= '0;
    end else begin
      if (adv) begin
        div_cnt <= '0;
        if (idx == IDX_LAST) begin
          idx <= 3'd0;
        end else begin
          idx <= idx + 3'd1;
        end
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
      if (wrap) begin
        snap <= '{
          sec:    sec,
          min:    min,
          hr:     hr,
          mode12: mode12
        };
      end
    end
  end

  // Hour conversion: 0 -> 12, 13..23 -> 1..11.
  always_comb begin
    h12 = snap.hr;
    if (snap.hr == 5'd0) begin
      h12 = 5'd12;
    end else if (snap.hr > 5'd12) begin
      h12 = snap.hr - 5'd12;
    end
  end

  assign hsel    = snap.mode12 ? h12 : snap.hr;
  assign hr_bcd  = to_bcd({1'b0, hsel});
  assign min_bcd = to_bcd(snap.min);
  assign sec_bcd = to_bcd(snap.sec);

  assign valid = (snap.sec <= 6'd59)
              && (snap.min <= 6'd59)
              && (snap.hr  <= 5'd23);

  assign tens_dark = snap.mode12
                  && (hr_bcd[7:4] == 4'd0);

  always_comb begin
    digit  = 4'd0;
    dark   = 1'b0;
    an_nxt = 6'b000000;
    unique case (idx)
      3'd0: begin
        digit  = hr_bcd[7:4];
        dark   = tens_dark;
        an_nxt = 6'b000001;
      end
      3'd1: begin
        digit  = hr_bcd[3:0];
        an_nxt = 6'b000010;
      end
      3'd2: begin
        digit  = min_bcd[7:4];
        an_nxt = 6'b000100;
      end
      3'd3: begin
        digit  = min_bcd[3:0];
        an_nxt = 6'b001000;
      end
      3'd4: begin
        digit  = sec_bcd[7:4];
        an_nxt = 6'b010000;
      end
      3'd5: begin
        digit  = sec_bcd[3:0];
        an_nxt = 6'b100000;
      end
      default: begin
        digit  = 4'd0;
        an_nxt = 6'b000000;
      end
    endcase
  end

  always_comb begin
    seg_nxt = enc7(digit);
    if (!valid) begin
      seg_nxt = SEG_DASH;
    end else if (dark) begin
      seg_nxt = SEG_OFF;
    end
  end

  // Colon lights on the hour/minute units digits on even seconds.
  assign dp_nxt = valid
               && !snap.sec[0]
               && ((idx == 3'd1) || (idx == 3'd3));

  assign pm_nxt = valid
               && snap.mode12
               && (snap.hr >= 5'd12);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= '0;
      seg <= '0;
      dp  <= 1'b0;
      pm  <= 1'b0;
    end else begin
      pm <= pm_nxt;
      if (blank_en) begin
        an  <= '0;
        seg <= '0;
        dp  <= 1'b0;
      end else begin
        an  <= an_nxt;
        seg <= seg_nxt;
        dp  <= dp_nxt;
      end
    end
  end

endmodule

// File: tb/tb_clock_display_driver.sv
// Directed bench for clock_display_driver (SCAN_DIV=4).
// Frames are checked cycle by cycle against hand-computed segment tables.
module tb_clock_display_driver;

  typedef logic [0:5][6:0] frame_t;

  logic       clk;
  logic       rst;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;
  logic       mode12;
  logic       blank_en;
  logic [5:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       pm;

  int checks;
  int failures;

  clock_display_driver #(
    .SCAN_DIV(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sec      (sec),
    .min      (min),
    .hr       (hr),
    .mode12   (mode12),
    .blank_en (blank_en),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .pm       (pm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(
    input logic [5:0] ea,
    input logic [6:0] es,
    input logic       ed,
    input logic       ep,
    input string      tag
  );
    chk({tag, ".an"}, 8'(an), 8'(ea));
    chk({tag, ".seg"}, 8'(seg), 8'(es));
    chk({tag, ".dp"}, 8'(dp), 8'(ed));
    chk({tag, ".pm"}, 8'(pm), 8'(ep));
  endtask

  task automatic check_cycle(
    input logic [5:0] ea,
    input logic [6:0] es,
    input logic       ed,
    input logic       ep,
    input string      tag
  );
    @(negedge clk);
    chk_out(ea, es, ed, ep, tag);
  endtask

  task automatic set_in(
    input int   h,
    input int   m,
    input int   s,
    input logic m12
  );
    hr     = 5'(h);
    min    = 6'(m);
    sec    = 6'(s);
    mode12 = m12;
  endtask

  task automatic frame_cycle(
    input int         k,
    input frame_t     f,
    input logic [0:5] dv,
    input logic       ep,
    input string      tag
  );
    check_cycle(6'(1 << (k / 4)), f[k / 4], dv[k / 4], ep,
                $sformatf("%s.d%0d.c%0d", tag, k / 4, k % 4));
  endtask

  task automatic check_frame(
    input frame_t     f,
    input logic [0:5] dv,
    input logic       ep,
    input string      tag
  );
    for (int k = 0; k < 24; k++) begin
      frame_cycle(k, f, dv, ep, tag);
    end
  endtask

  task automatic check_stall(input string tag);
    for (int k = 0; k < 4; k++) begin
      check_cycle(6'b100000, 7'h3F, 1'b0, 1'b0,
                  $sformatf("%s.c%0d", tag, k));
    end
  endtask

  frame_t fr_a = {7'h3F, 7'h07, 7'h3F, 7'h6D, 7'h66, 7'h5B};
  frame_t fr_b = {7'h06, 7'h5B, 7'h3F, 7'h3F, 7'h3F, 7'h06};
  frame_t fr_c = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
  frame_t fr_d = {7'h00, 7'h06, 7'h6D, 7'h6F, 7'h3F, 7'h7F};
  frame_t fr_e = {7'h06, 7'h06, 7'h06, 7'h7F, 7'h5B, 7'h6F};
  frame_t fr_f = {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  frame_t fr_g = {7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h06, 7'h3F};
  frame_t fr_h = {7'h06, 7'h6F, 7'h5B, 7'h3F, 7'h66, 7'h06};
  frame_t fr_i = {7'h06, 7'h6F, 7'h5B, 7'h3F, 7'h66, 7'h5B};
  frame_t fr_j = {7'h00, 7'h07, 7'h5B, 7'h3F, 7'h66, 7'h5B};
  frame_t fr_k = {7'h3F, 7'h6F, 7'h3F, 7'h6F, 7'h3F, 7'h7F};

  localparam logic [0:5] DP_ON  = 6'b010100;
  localparam logic [0:5] DP_OFF = 6'b000000;

  initial begin
    checks   = 0;
    failures = 0;
    blank_en = 1'b0;
    rst      = 1'b0;
    set_in(7, 5, 42, 1'b0);
    #1 rst = 1'b1;

    @(negedge clk);
    chk_out(6'b0, 7'h00, 1'b0, 1'b0, "reset0");
    @(negedge clk);
    chk_out(6'b0, 7'h00, 1'b0, 1'b0, "reset1");
    rst = 1'b0;

    check_stall("stall");

    set_in(0, 0, 1, 1'b1);
    check_frame(fr_a, DP_ON, 1'b0, "h07m05s42");
    set_in(12, 34, 56, 1'b1);
    check_frame(fr_b, DP_OFF, 1'b0, "12h_hr0");
    set_in(13, 59, 8, 1'b1);
    check_frame(fr_c, DP_ON, 1'b1, "12h_hr12");
    set_in(23, 18, 29, 1'b1);
    check_frame(fr_d, DP_ON, 1'b1, "12h_hr13");
    set_in(23, 60, 10, 1'b1);
    check_frame(fr_e, DP_OFF, 1'b1, "12h_hr23");
    set_in(23, 59, 10, 1'b0);
    check_frame(fr_f, DP_OFF, 1'b0, "min60");
    set_in(19, 20, 41, 1'b0);
    check_frame(fr_g, DP_ON, 1'b0, "min59");

    for (int k = 0; k < 24; k++) begin
      if (k == 13) sec = 6'd42;
      frame_cycle(k, fr_h, DP_OFF, 1'b0, "sec41_hold");
    end

    set_in(19, 20, 42, 1'b1);
    check_frame(fr_i, DP_ON, 1'b0, "sec42_next");

    set_in(9, 9, 8, 1'b0);
    for (int k = 0; k < 24; k++) begin
      if (k == 4) blank_en = 1'b1;
      if (k == 14) blank_en = 1'b0;
      if (k >= 4 && k < 14) begin
        check_cycle(6'b0, 7'h00, 1'b0, 1'b1,
                    $sformatf("blank.c%0d", k));
      end else begin
        frame_cycle(k, fr_j, DP_ON, 1'b1, "blank_frame");
      end
    end

    for (int k = 0; k < 6; k++) begin
      frame_cycle(k, fr_k, DP_ON, 1'b0, "pre_rst");
    end
    #2 rst = 1'b1;
    #1 chk_out(6'b0, 7'h00, 1'b0, 1'b0, "async_rst");
    @(negedge clk);
    chk_out(6'b0, 7'h00, 1'b0, 1'b0, "rst_held");
    rst = 1'b0;

    check_stall("stall2");
    check_frame(fr_k, DP_ON, 1'b0, "fresh_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
